// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and small helpers for the shared-ALU controller.
package alu_ctrl_pkg;

  localparam int unsigned ALU_DATA_W = 8;   // operand/result width of the attached ALU
  localparam int unsigned ALU_SEL_W  = 4;   // ALU function-select width
  localparam int unsigned OP_CNT_W   = 16;  // completed-operation counter width
  localparam int unsigned NUM_REQ    = 2;   // number of requesters
  localparam int unsigned REQ_ID_W   = 1;   // requester-id width

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester id to one-hot per-requester vector.
  function automatic logic [NUM_REQ-1:0] id2onehot(input req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the shared-ALU controller: two request channels in,
// one shared response bus with per-requester valid/ready out.
//   master : client side (drives requests, accepts responses)
//   slave  : controller side
interface alu_share_ctrl_if #(
  parameter int unsigned DATA_W = alu_ctrl_pkg::ALU_DATA_W,
  parameter int unsigned SEL_W  = alu_ctrl_pkg::ALU_SEL_W
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_cin;
  logic [SEL_W-1:0]  req0_s;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_cin;
  logic [SEL_W-1:0]  req1_s;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_d;
  logic              rsp_z;
  logic              rsp_cout;

  modport master (
    output req_valid, req0_a, req0_b, req0_cin, req0_s,
           req1_a, req1_b, req1_cin, req1_s, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_z, rsp_cout
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_cin, req0_s,
           req1_a, req1_b, req1_cin, req1_s, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_z, rsp_cout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   valid     : per-requester request vector
//   ptr       : requester preferred when both are valid
//   gnt_id_c  : granted requester id (meaningful only when gnt_any_c)
//   gnt_any_c : at least one requester is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt_id_c,
  output logic       gnt_any_c
);

  always_comb begin
    gnt_any_c = |valid;
    gnt_id_c  = 1'b0;
    unique case (valid)
      2'b01:   gnt_id_c = 1'b0;
      2'b10:   gnt_id_c = 1'b1;
      2'b11:   gnt_id_c = ptr;
      default: gnt_id_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters.
// Round-robin arbitration, operands registered onto the ALU inputs, result
// captured one cycle later and returned to the owner with valid/ready.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : request channels and shared response bus
//   alu_a/b/cin/s     : registered operands toward the ALU
//   alu_d/z/cout      : ALU result inputs
//   busy              : controller not idle
//   op_count          : completed responses, wraps
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned SEL_W  = ALU_SEL_W,
  parameter int unsigned CNT_W  = OP_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [SEL_W-1:0]  alu_s,
  input  logic [DATA_W-1:0] alu_d,
  input  logic              alu_z,
  input  logic              alu_cout,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state_q, state_d;
  req_id_t           owner_q, owner_d;
  req_id_t           ptr_q, ptr_d;
  logic              ld_op_c;
  logic              cap_res_c;
  logic              done_c;
  logic [1:0]        req_ready_c;
  logic              gnt_id_c;
  logic              gnt_any_c;

  logic [DATA_W-1:0] sel_a_c, sel_b_c;
  logic              sel_cin_c;
  logic [SEL_W-1:0]  sel_s_c;

  logic [DATA_W-1:0] res_d_q;
  logic              res_z_q;
  logic              res_cout_q;
  logic [1:0]        rsp_valid_q;
  logic              busy_q;
  logic [CNT_W-1:0]  op_count_q;

  // Grant selection among valid requesters.
  rr_arb2 u_arb (
    .valid     (bus.req_valid),
    .ptr       (ptr_q),
    .gnt_id_c  (gnt_id_c),
    .gnt_any_c (gnt_any_c)
  );

  // Operand source for the granted requester.
  always_comb begin
    sel_a_c   = gnt_id_c ? bus.req1_a   : bus.req0_a;
    sel_b_c   = gnt_id_c ? bus.req1_b   : bus.req0_b;
    sel_cin_c = gnt_id_c ? bus.req1_cin : bus.req0_cin;
    sel_s_c   = gnt_id_c ? bus.req1_s   : bus.req0_s;
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    ld_op_c     = 1'b0;
    cap_res_c   = 1'b0;
    done_c      = 1'b0;
    req_ready_c = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          req_ready_c = id2onehot(gnt_id_c);
          ld_op_c     = 1'b1;
          owner_d     = gnt_id_c;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        cap_res_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the response.
        if (bus.rsp_ready[owner_q]) begin
          done_c  = 1'b1;
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Operand registers hold between operations so the ALU inputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_s   <= '0;
    end else if (ld_op_c) begin
      alu_a   <= sel_a_c;
      alu_b   <= sel_b_c;
      alu_cin <= sel_cin_c;
      alu_s   <= sel_s_c;
    end
  end

  // Result capture at the end of the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_d_q    <= '0;
      res_z_q    <= 1'b0;
      res_cout_q <= 1'b0;
    end else if (cap_res_c) begin
      res_d_q    <= alu_d;
      res_z_q    <= alu_z;
      res_cout_q <= alu_cout;
    end
  end

  // Registered status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      rsp_valid_q <= (state_d == RESP) ? id2onehot(owner_d) : 2'b00;
      busy_q      <= (state_d != IDLE);
      if (done_c) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_d     = res_d_q;
  assign bus.rsp_z     = res_z_q;
  assign bus.rsp_cout  = res_cout_q;
  assign busy          = busy_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an adder stub standing in for the ALU.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  alu_a, alu_b, alu_d;
  logic        alu_cin, alu_z, alu_cout;
  logic [3:0]  alu_s;
  logic        busy;
  logic [15:0] op_count;
  logic [8:0]  sum9;

  int vectors;
  int miscompares;

  alu_share_ctrl_if bus ();

  alu_share_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_s    (alu_s),
    .alu_d    (alu_d),
    .alu_z    (alu_z),
    .alu_cout (alu_cout),
    .busy     (busy),
    .op_count (op_count)
  );

  // ALU stub: D = A + B + Cin, Cout = carry, Z = (D == 0).
  assign sum9     = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
  assign alu_d    = sum9[7:0];
  assign alu_cout = sum9[8];
  assign alu_z    = (sum9[7:0] == 8'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req0(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_s = 4'h0;
  endtask

  task automatic set_req1(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_s = 4'h0;
  endtask

  // Reset pulse; returns just after a falling edge with rst_n released.
  task automatic do_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    vectors++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_cin !== 1'b0) begin miscompares++; $display("FAIL reset_operands got=%h/%h/%b exp=00/00/0", alu_a, alu_b, alu_cin); end
    vectors++; if (op_count !== 16'h0000) begin miscompares++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_req0(8'h03, 8'h04, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (busy !== 1'b1 || bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_exec got busy=%b rsp_valid=%b exp 1/00", busy, bus.rsp_valid); end
    vectors++; if (alu_a !== 8'h03 || alu_b !== 8'h04) begin miscompares++; $display("FAIL single_operands got=%h/%h exp=03/04", alu_a, alu_b); end
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=01", bus.rsp_valid); end
    vectors++; if (bus.rsp_d !== 8'h07 || bus.rsp_z !== 1'b0 || bus.rsp_cout !== 1'b0) begin miscompares++; $display("FAIL single_result got d=%h z=%b c=%b exp 07/0/0", bus.rsp_d, bus.rsp_z, bus.rsp_cout); end
    @(negedge clk);
    vectors++; if (op_count !== 16'd1 || busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_done got cnt=%h busy=%b rv=%b exp 0001/0/00", op_count, busy, bus.rsp_valid); end
    vectors++; if (alu_a !== 8'h03) begin miscompares++; $display("FAIL single_hold got=%h exp=03", alu_a); end
  endtask

  task automatic test_both();
    do_reset();
    set_req0(8'h03, 8'h04, 1'b1);
    set_req1(8'hFF, 8'h01, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL both_ready0 got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b10;
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 2'b01 || bus.rsp_d !== 8'h08 || bus.rsp_z !== 1'b0 || bus.rsp_cout !== 1'b0) begin miscompares++; $display("FAIL both_rsp0 got rv=%b d=%h z=%b c=%b exp 01/08/0/0", bus.rsp_valid, bus.rsp_d, bus.rsp_z, bus.rsp_cout); end
    @(negedge clk);
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL both_ready1 got=%b exp=10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_d !== 8'h00 || bus.rsp_z !== 1'b1 || bus.rsp_cout !== 1'b1) begin miscompares++; $display("FAIL both_rsp1 got rv=%b d=%h z=%b c=%b exp 10/00/1/1", bus.rsp_valid, bus.rsp_d, bus.rsp_z, bus.rsp_cout); end
    @(negedge clk);
    vectors++; if (op_count !== 16'd2 || busy !== 1'b0) begin miscompares++; $display("FAIL both_count got cnt=%h busy=%b exp 0002/0", op_count, busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    set_req0(8'h10, 8'h01, 1'b0);
    set_req1(8'h20, 8'h02, 1'b0);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      vectors++; if (bus.req_ready !== exp_g) begin miscompares++; $display("FAIL fair_grant[%0d] got=%b exp=%b", i, bus.req_ready, exp_g); end
      @(negedge clk);
      @(negedge clk);
      vectors++; if (bus.rsp_valid !== exp_g || bus.rsp_d !== exp_d) begin miscompares++; $display("FAIL fair_rsp[%0d] got rv=%b d=%h exp %b/%h", i, bus.rsp_valid, bus.rsp_d, exp_g, exp_d); end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    vectors++; if (op_count !== 16'd6) begin miscompares++; $display("FAIL fair_count got=%h exp=0006", op_count); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.rsp_ready = 2'b00;
    set_req1(8'h05, 8'h06, 1'b1);
    bus.req_valid = 2'b10;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL stall_ready got=%b exp=10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    // Other requester pushes and pulls during the stall; neither may matter.
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_d !== 8'h0C) begin miscompares++; $display("FAIL stall_rsp[%0d] got rv=%b d=%h exp 10/0c", i, bus.rsp_valid, bus.rsp_d); end
      vectors++; if (bus.req_ready !== 2'b00 || busy !== 1'b1) begin miscompares++; $display("FAIL stall_state[%0d] got ready=%b busy=%b exp 00/1", i, bus.req_ready, busy); end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00 || op_count !== 16'd1) begin miscompares++; $display("FAIL stall_release got busy=%b rv=%b cnt=%h exp 0/00/0001", busy, bus.rsp_valid, op_count); end
    bus.rsp_ready = 2'b11;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req0(8'h01, 8'h01, 1'b0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    set_req0(8'hAA, 8'h01, 1'b0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    vectors++; if (alu_a !== 8'hAA || op_count !== 16'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got a=%h cnt=%h busy=%b exp aa/0001/1", alu_a, op_count, busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags got rv=%b busy=%b exp 00/0", bus.rsp_valid, busy); end
    vectors++; if (alu_a !== 8'h00 || op_count !== 16'd0) begin miscompares++; $display("FAIL rstmid_regs got a=%h cnt=%h exp 00/0000", alu_a, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_after[%0d] got rv=%b busy=%b exp 00/0", i, bus.rsp_valid, busy); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    #1;
    vectors++; if (op_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload got=%h exp=ffff", op_count); end
    set_req1(8'h80, 8'h80, 1'b0);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_d !== 8'h00 || bus.rsp_z !== 1'b1 || bus.rsp_cout !== 1'b1) begin miscompares++; $display("FAIL wrap_rsp got rv=%b d=%h z=%b c=%b exp 10/00/1/1", bus.rsp_valid, bus.rsp_d, bus.rsp_z, bus.rsp_cout); end
    @(negedge clk);
    vectors++; if (op_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_count got=%h exp=0000", op_count); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    set_req0(8'h00, 8'h00, 1'b0);
    set_req1(8'h00, 8'h00, 1'b0);
    test_reset();
    test_single();
    test_both();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
